// File: rtl/z80_bus_ctrl.sv
// Bus and interrupt glue for a Z80-family soft core.
// Provides the CPU clock enable, the read-data latch, edge-triggered maskable
// interrupts with IM1/IM2 vector supply, an NMI pulse generator and
// wait-state insertion for slow memory.

// One interrupt channel: rising-edge detect plus a pending bit.
// On the same cycle, a new edge takes priority over a clear.
module z80_irq_lane (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  input  logic clr,
  output logic pend
);
  logic prev_q, pend_q, pend_d, rise;

  assign rise   = req & ~prev_q;
  assign pend_d = (pend_q & ~clr) | rise;
  assign pend   = pend_q;

  // Edge register resets high so a source already high at release is not an edge
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      prev_q <= req;
      pend_q <= pend_d;
    end
  end
endmodule

module z80_bus_ctrl #(
  parameter int         CEN_DIV     = 16,
  parameter int         IRQ_CH      = 4,
  parameter bit         IM2         = 1'b1,
  parameter logic [7:0] VEC_BASE    = 8'hE0,
  parameter int         NMI_WIDTH   = 4,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  output logic              cen,
  input  logic              cpu_m1_n,
  input  logic              cpu_mreq_n,
  input  logic              cpu_iorq_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  output logic              cpu_int_n,
  output logic              cpu_nmi_n,
  output logic              cpu_wait_n,
  output logic [7:0]        cpu_di,
  input  logic [7:0]        bus_din,
  input  logic              bus_slow,
  input  logic [IRQ_CH-1:0] irq_req,
  input  logic [IRQ_CH-1:0] irq_en,
  output logic [IRQ_CH-1:0] irq_pending,
  input  logic              nmi_req
);

  // ---------------------------------------------------------------------
  // Clock enable
  // ---------------------------------------------------------------------
  logic [7:0] cen_cnt_q, cen_cnt_d;
  logic       cen_q;

  // Divider wraps at CEN_DIV-1; cen is the registered wrap indication
  always_comb begin
    cen_cnt_d = cen_cnt_q + 8'd1;
    if (cen_cnt_q == 8'(CEN_DIV - 1)) cen_cnt_d = 8'd0;
  end

  // Divider and cen registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cen_cnt_q <= 8'd0;
      cen_q     <= 1'b0;
    end else begin
      cen_cnt_q <= cen_cnt_d;
      cen_q     <= (cen_cnt_q == 8'(CEN_DIV - 1));
    end
  end

  assign cen = cen_q;

  // ---------------------------------------------------------------------
  // Maskable interrupts
  // ---------------------------------------------------------------------
  logic [IRQ_CH-1:0] pend, act, clr;
  logic [2:0]        sel_k;
  logic              hit;
  logic              ack_q, ack_det;
  logic [7:0]        vec;
  logic              int_n_q;

  for (genvar g = 0; g < IRQ_CH; g++) begin : g_lane
    z80_irq_lane u_lane (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .req     (irq_req[g]),
      .clr     (clr[g]),
      .pend    (pend[g])
    );
  end

  assign irq_pending = pend;
  assign act         = pend & irq_en;

  // Acknowledge fires only on the first cycle of M1+IORQ; ack_q marks the rest
  assign ack_det = ~cpu_m1_n & ~cpu_iorq_n & ~ack_q;

  // Lowest-index pending and enabled channel wins; scan high to low so the
  // last assignment is the lowest index
  always_comb begin
    hit   = 1'b0;
    sel_k = 3'd0;
    clr   = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (act[i]) begin
        hit    = 1'b1;
        sel_k  = 3'(i);
        clr    = '0;
        clr[i] = ack_det;
      end
    end
  end

  // Vector byte: IM2 gives base | k<<1 (base alone when spurious), IM1 gives RST 38h
  always_comb begin
    vec = 8'hFF;
    if (IM2) begin
      vec = VEC_BASE;
      if (hit) vec = VEC_BASE | {4'd0, sel_k, 1'b0};
    end
  end

  // Acknowledge tracking and the registered interrupt request
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      int_n_q <= 1'b1;
    end else begin
      ack_q   <= ~cpu_iorq_n & (ack_q | ack_det);
      int_n_q <= ~|act;
    end
  end

  assign cpu_int_n = int_n_q;

  // ---------------------------------------------------------------------
  // CPU data-in latch
  // ---------------------------------------------------------------------
  logic [7:0] di_q, di_d;

  // Vector capture beats the read latch; the vector is held for the whole ack
  always_comb begin
    di_d = di_q;
    if (ack_det)        di_d = vec;
    else if (ack_q)     di_d = di_q;
    else if (!cpu_rd_n) di_d = bus_din;
  end

  // Data-in register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) di_q <= 8'hFF;
    else          di_q <= di_d;
  end

  assign cpu_di = di_q;

  // ---------------------------------------------------------------------
  // NMI pulse generator
  // ---------------------------------------------------------------------
  logic       nmi_prev_q, nmi_n_q;
  logic [7:0] nmi_cnt_q, nmi_cnt_d;
  logic       nmi_rise;

  assign nmi_rise = nmi_req & ~nmi_prev_q;

  // Edges during an active pulse are dropped rather than queued
  always_comb begin
    nmi_cnt_d = nmi_cnt_q;
    if (nmi_rise && nmi_cnt_q == 8'd0) nmi_cnt_d = 8'(NMI_WIDTH);
    else if (cen_q && nmi_cnt_q != 8'd0) nmi_cnt_d = nmi_cnt_q - 8'd1;
  end

  // NMI counter and output; output follows the counter one cycle behind
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      nmi_prev_q <= 1'b1;
      nmi_cnt_q  <= 8'd0;
      nmi_n_q    <= 1'b1;
    end else begin
      nmi_prev_q <= nmi_req;
      nmi_cnt_q  <= nmi_cnt_d;
      nmi_n_q    <= (nmi_cnt_q == 8'd0);
    end
  end

  assign cpu_nmi_n = nmi_n_q;

  // ---------------------------------------------------------------------
  // Wait-state insertion
  // ---------------------------------------------------------------------
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       done_q, done_d;
  logic       wait_n_q;
  logic       slow_start;

  // Refresh has both rd_n and wr_n high, so it never starts a wait
  assign slow_start = ~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n) & bus_slow & ~done_q;

  // One wait sequence per access; mreq_n high aborts and re-arms
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    done_d     = done_q;
    if (cpu_mreq_n) begin
      wait_cnt_d = 8'd0;
      done_d     = 1'b0;
    end else if (slow_start) begin
      wait_cnt_d = 8'(WAIT_CYCLES);
      done_d     = 1'b1;
    end else if (cen_q && wait_cnt_q != 8'd0) begin
      wait_cnt_d = wait_cnt_q - 8'd1;
    end
  end

  // Wait registers; wait_n is taken from next state so it drops one cycle after start
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wait_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      wait_n_q   <= 1'b1;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      done_q     <= done_d;
      wait_n_q   <= (wait_cnt_d == 8'd0);
    end
  end

  assign cpu_wait_n = wait_n_q;

endmodule
